wb_master_port: RTL and testbench

Single-outstanding Wishbone (pipelined) bus initiator. It converts a valid/ready request and response interface from a core-side client (fetch unit, DMA, debug) into bus cycles toward the system-bus slaves (SRAM controller, peripherals). It handles stall, ack, err and rty terminations, bounded retry and a per-attempt timeout, so a dead slave can never hang the client.

---
 rtl/wb_master_port.sv | 176 +++++++++++++++++
 tb/tb_wb_master_port.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/wb_master_port.sv
// Single-outstanding pipelined Wishbone initiator with a valid/ready client side.
// Handles stall, ack/err/rty terminations, bounded retry and a per-attempt timeout.
module wb_master_port #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        clk_bus,
  input  logic        rst_bus,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dat,
  input  logic [3:0]  req_sel,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_dat,
  output logic [1:0]  resp_code,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i,
  input  logic        stall_i
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [1:0] CODE_OK  = 2'b00;
  localparam logic [1:0] CODE_ERR = 2'b01;
  localparam logic [1:0] CODE_TMO = 2'b10;
  localparam logic [1:0] CODE_RTY = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_BACKOFF,
    S_RESP
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
  logic [RW-1:0] retry_cnt, retry_cnt_nxt;
  logic          cyc_nxt, stb_nxt, we_nxt;
  logic [31:0]   adr_nxt, dat_nxt;
  logic [3:0]    sel_nxt;
  logic          resp_valid_nxt;
  logic [31:0]   resp_dat_nxt;
  logic [1:0]    resp_code_nxt;
  logic          strobe_ok;

  assign req_ready = (state == S_IDLE);

  // Next-state and next-output logic; every register has a next value here.
  always_comb begin
    state_nxt      = state;
    tmo_cnt_nxt    = tmo_cnt;
    retry_cnt_nxt  = retry_cnt;
    cyc_nxt        = cyc_o;
    stb_nxt        = stb_o;
    we_nxt         = we_o;
    adr_nxt        = adr_o;
    dat_nxt        = dat_o;
    sel_nxt        = sel_o;
    resp_valid_nxt = resp_valid;
    resp_dat_nxt   = resp_dat;
    resp_code_nxt  = resp_code;
    // A termination in REQ only counts when the strobe is taken that cycle.
    strobe_ok      = (state == S_WAIT) || ((state == S_REQ) && !stall_i);

    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          we_nxt        = req_we;
          adr_nxt       = req_adr;
          dat_nxt       = req_dat;
          sel_nxt       = req_sel;
          retry_cnt_nxt = '0;
          tmo_cnt_nxt   = '0;
          cyc_nxt       = 1'b1;
          stb_nxt       = 1'b1;
          state_nxt     = S_REQ;
        end
      end

      S_REQ, S_WAIT: begin
        tmo_cnt_nxt = tmo_cnt + TW'(1);
        if (strobe_ok && (ack_i || err_i)) begin
          cyc_nxt        = 1'b0;
          stb_nxt        = 1'b0;
          resp_valid_nxt = 1'b1;
          resp_code_nxt  = ack_i ? CODE_OK : CODE_ERR;
          resp_dat_nxt   = (ack_i && !we_o) ? dat_i : 32'h0;
          state_nxt      = S_RESP;
        end else if (strobe_ok && rty_i) begin
          cyc_nxt = 1'b0;
          stb_nxt = 1'b0;
          if (retry_cnt < RW'(MAX_RETRY)) begin
            retry_cnt_nxt = retry_cnt + RW'(1);
            state_nxt     = S_BACKOFF;
          end else begin
            resp_valid_nxt = 1'b1;
            resp_code_nxt  = CODE_RTY;
            resp_dat_nxt   = 32'h0;
            state_nxt      = S_RESP;
          end
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          cyc_nxt        = 1'b0;
          stb_nxt        = 1'b0;
          resp_valid_nxt = 1'b1;
          resp_code_nxt  = CODE_TMO;
          resp_dat_nxt   = 32'h0;
          state_nxt      = S_RESP;
        end else if (strobe_ok && (state == S_REQ)) begin
          stb_nxt   = 1'b0;
          state_nxt = S_WAIT;
        end
      end

      S_BACKOFF: begin
        cyc_nxt     = 1'b1;
        stb_nxt     = 1'b1;
        tmo_cnt_nxt = '0;
        state_nxt   = S_REQ;
      end

      S_RESP: begin
        if (resp_ready) begin
          resp_valid_nxt = 1'b0;
          state_nxt      = S_IDLE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // All state and bus/client outputs registered together.
  always_ff @(posedge clk_bus or negedge rst_bus) begin
    if (!rst_bus) begin
      state      <= S_IDLE;
      tmo_cnt    <= '0;
      retry_cnt  <= '0;
      cyc_o      <= 1'b0;
      stb_o      <= 1'b0;
      we_o       <= 1'b0;
      adr_o      <= 32'h0;
      dat_o      <= 32'h0;
      sel_o      <= 4'h0;
      resp_valid <= 1'b0;
      resp_dat   <= 32'h0;
      resp_code  <= CODE_OK;
    end else begin
      state      <= state_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      retry_cnt  <= retry_cnt_nxt;
      cyc_o      <= cyc_nxt;
      stb_o      <= stb_nxt;
      we_o       <= we_nxt;
      adr_o      <= adr_nxt;
      dat_o      <= dat_nxt;
      sel_o      <= sel_nxt;
      resp_valid <= resp_valid_nxt;
      resp_dat   <= resp_dat_nxt;
      resp_code  <= resp_code_nxt;
    end
  end

endmodule

// File: tb/tb_wb_master_port.sv
// Directed testbench for wb_master_port; a procedural slave model answers strobes
// one cycle after acceptance with a scripted sequence of terminations.
module tb_wb_master_port;

  logic        clk_bus = 1'b0;
  logic        rst_bus;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_adr, req_dat;
  logic [3:0]  req_sel;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_dat;
  logic [1:0]  resp_code;
  logic        cyc_o, stb_o, we_o;
  logic [31:0] adr_o, dat_o, dat_i;
  logic [3:0]  sel_o;
  logic        ack_i, err_i, rty_i, stall_i;

  int checks = 0;
  int errors = 0;

  // Slave termination modes after the scripted retries.
  localparam int M_ACK = 0, M_ERR = 1, M_BOTH = 2, M_NONE = 3;

  wb_master_port #(.TIMEOUT(255), .MAX_RETRY(3)) dut (
    .clk_bus(clk_bus), .rst_bus(rst_bus),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_dat(resp_dat), .resp_code(resp_code),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o),
    .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i), .stall_i(stall_i)
  );

  always #5 clk_bus = ~clk_bus;

  // Issues one request, plays the slave, records what it saw, then consumes the response.
  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int stall_n, input int rty_n,
                        input int mode, input logic [31:0] rdata,
                        output int strobes, output int stb_hi, output int cyc_hi,
                        output int gaps, output int lat, output logic stable,
                        output logic rdy_resp, output logic [31:0] rdat,
                        output logic [1:0] rcode, output logic tmo);
    logic pend;
    int   stall_left;
    pend = 1'b0; stall_left = stall_n;
    strobes = 0; stb_hi = 0; cyc_hi = 0; gaps = 0; lat = -1;
    stable = 1'b1; rdy_resp = 1'bx; rdat = 'x; rcode = 'x; tmo = 1'b1;
    @(negedge clk_bus);
    req_valid = 1'b1; req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
    dat_i = rdata;
    @(posedge clk_bus);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk_bus);
      req_valid = 1'b0;
      if (resp_valid) begin
        lat = k; rdat = resp_dat; rcode = resp_code; rdy_resp = req_ready; tmo = 1'b0;
        break;
      end
      ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
      if (pend) begin
        if (strobes <= rty_n) rty_i = 1'b1;
        else if (mode == M_ACK) ack_i = 1'b1;
        else if (mode == M_ERR) err_i = 1'b1;
        else if (mode == M_BOTH) begin ack_i = 1'b1; err_i = 1'b1; end
        pend = 1'b0;
      end
      if (cyc_o) cyc_hi++; else gaps++;
      stall_i = 1'b0;
      if (stb_o) begin
        stb_hi++;
        if (we_o !== we || adr_o !== adr || dat_o !== dat || sel_o !== sel) stable = 1'b0;
        if (stall_left > 0) begin stall_i = 1'b1; stall_left--; end
        else begin pend = 1'b1; strobes++; end
      end
    end
    ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; stall_i = 1'b0;
    if (!tmo) begin
      resp_ready = 1'b1;
      @(negedge clk_bus);
      resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_bus = 1'b0;
    req_valid = 0; req_we = 0; req_adr = 0; req_dat = 0; req_sel = 0; resp_ready = 0;
    dat_i = 0; ack_i = 0; err_i = 0; rty_i = 0; stall_i = 0;
    repeat (3) @(negedge clk_bus);
    checks++; if ({cyc_o, stb_o, we_o} !== 3'b000) begin errors++; $display("FAIL rst_ctl got %b want 000", {cyc_o, stb_o, we_o}); end
    checks++; if ({adr_o, dat_o, sel_o} !== 68'h0) begin errors++; $display("FAIL rst_bus_fields got %h want 0", {adr_o, dat_o, sel_o}); end
    checks++; if ({resp_valid, resp_dat, resp_code} !== 35'h0) begin errors++; $display("FAIL rst_resp got %h want 0", {resp_valid, resp_dat, resp_code}); end
    rst_bus = 1'b1;
    @(negedge clk_bus);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", req_ready); end
  endtask

  task automatic test_read;
    int s, sh, ch, g, l; logic st, rr, t; logic [31:0] d; logic [1:0] c;
    do_txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 0, 0, M_ACK, 32'hDEAD_BEEF, s, sh, ch, g, l, st, rr, d, c, t);
    checks++; if (t !== 1'b0) begin errors++; $display("FAIL rd_bound got timeout=%b want 0", t); end
    checks++; if (sh !== 1) begin errors++; $display("FAIL rd_stb_cycles got %0d want 1", sh); end
    checks++; if (l !== 2) begin errors++; $display("FAIL rd_latency got %0d want 2", l); end
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", d); end
    checks++; if (c !== 2'b00) begin errors++; $display("FAIL rd_code got %b want 00", c); end
    checks++; if (rr !== 1'b0) begin errors++; $display("FAIL rd_ready_in_resp got %b want 0", rr); end
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL rd_after_consume got %b want 01", {resp_valid, req_ready}); end
  endtask

  task automatic test_write_stall;
    int s, sh, ch, g, l; logic st, rr, t; logic [31:0] d; logic [1:0] c;
    do_txn(1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011, 2, 0, M_ACK, 32'hCAFE_F00D, s, sh, ch, g, l, st, rr, d, c, t);
    checks++; if (t !== 1'b0) begin errors++; $display("FAIL wr_bound got timeout=%b want 0", t); end
    checks++; if (sh !== 3) begin errors++; $display("FAIL wr_stb_cycles got %0d want 3", sh); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL wr_fields_stable got %b want 1", st); end
    checks++; if (c !== 2'b00) begin errors++; $display("FAIL wr_code got %b want 00", c); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL wr_data got %h want 0", d); end
  endtask

  task automatic test_retry;
    int s, sh, ch, g, l; logic st, rr, t; logic [31:0] d; logic [1:0] c;
    do_txn(1'b0, 32'h0000_0030, 32'h0, 4'hF, 0, 2, M_ACK, 32'h0BAD_F00D, s, sh, ch, g, l, st, rr, d, c, t);
    checks++; if (s !== 3) begin errors++; $display("FAIL rty2_strobes got %0d want 3", s); end
    checks++; if (g !== 2) begin errors++; $display("FAIL rty2_gaps got %0d want 2", g); end
    checks++; if (c !== 2'b00 || d !== 32'h0BAD_F00D) begin errors++; $display("FAIL rty2_resp got %b/%h want 00/0badf00d", c, d); end
    do_txn(1'b0, 32'h0000_0034, 32'h0, 4'hF, 0, 4, M_ACK, 32'h1111_2222, s, sh, ch, g, l, st, rr, d, c, t);
    checks++; if (s !== 4) begin errors++; $display("FAIL rty4_strobes got %0d want 4", s); end
    checks++; if (g !== 3) begin errors++; $display("FAIL rty4_gaps got %0d want 3", g); end
    checks++; if (c !== 2'b11 || d !== 32'h0) begin errors++; $display("FAIL rty4_resp got %b/%h want 11/0", c, d); end
  endtask

  task automatic test_timeout;
    int s, sh, ch, g, l; logic st, rr, t; logic [31:0] d; logic [1:0] c;
    do_txn(1'b0, 32'h0000_0040, 32'h0, 4'hF, 0, 0, M_NONE, 32'h5555_5555, s, sh, ch, g, l, st, rr, d, c, t);
    checks++; if (t !== 1'b0) begin errors++; $display("FAIL tmo_bound got timeout=%b want 0", t); end
    checks++; if (ch !== 255) begin errors++; $display("FAIL tmo_cyc_cycles got %0d want 255", ch); end
    checks++; if (c !== 2'b10 || d !== 32'h0) begin errors++; $display("FAIL tmo_resp got %b/%h want 10/0", c, d); end
  endtask

  task automatic test_back_to_back;
    int s, sh, ch, g, l; logic st, rr, t; logic [31:0] d; logic [1:0] c;
    do_txn(1'b0, 32'h0000_0044, 32'h0, 4'hF, 0, 0, M_ACK, 32'h0000_A5A5, s, sh, ch, g, l, st, rr, d, c, t);
    checks++; if (l !== 2 || d !== 32'h0000_A5A5) begin errors++; $display("FAIL b2b_resp got lat %0d data %h want 2/0000a5a5", l, d); end
  endtask

  task automatic test_priority;
    int s, sh, ch, g, l; logic st, rr, t; logic [31:0] d; logic [1:0] c;
    do_txn(1'b0, 32'h0000_0050, 32'h0, 4'hF, 0, 0, M_BOTH, 32'h5A5A_5A5A, s, sh, ch, g, l, st, rr, d, c, t);
    checks++; if (c !== 2'b00 || d !== 32'h5A5A_5A5A) begin errors++; $display("FAIL prio_ack_err got %b/%h want 00/5a5a5a5a", c, d); end
    do_txn(1'b0, 32'h0000_0054, 32'h0, 4'hF, 0, 0, M_ERR, 32'h7777_7777, s, sh, ch, g, l, st, rr, d, c, t);
    checks++; if (c !== 2'b01 || d !== 32'h0) begin errors++; $display("FAIL err_only got %b/%h want 01/0", c, d); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk_bus);
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h0000_0060; req_sel = 4'hF;
    @(negedge clk_bus);
    req_valid = 1'b0;
    @(negedge clk_bus);
    checks++; if ({cyc_o, stb_o} !== 2'b10) begin errors++; $display("FAIL mid_in_wait got %b want 10", {cyc_o, stb_o}); end
    #2 rst_bus = 1'b0;
    #1;
    checks++; if ({cyc_o, stb_o} !== 2'b00) begin errors++; $display("FAIL mid_async_drop got %b want 00", {cyc_o, stb_o}); end
    @(negedge clk_bus);
    rst_bus = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ack_i = 1'b1; err_i = (i == 1);
      @(negedge clk_bus);
      checks++;
      if ({req_ready, resp_valid, cyc_o} !== 3'b100) begin
        errors++; $display("FAIL mid_ignore_ack[%0d] got %b want 100", i, {req_ready, resp_valid, cyc_o});
      end
    end
    ack_i = 1'b0; err_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_stall();
    test_retry();
    test_timeout();
    test_back_to_back();
    test_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
